// File: rtl/dff_bank_seq.sv
// dff_bank_seq: command sequencer driving a flip-flop bank's pre/clr/ce/d/mode lines with readback check
module dff_bank_seq #(
  parameter int WIDTH = 8,
  parameter int PULSE_LEN = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             ff_pre_n,
  output logic             ff_clr_n,
  output logic             ff_ce,
  output logic             ff_mode,
  output logic [WIDTH-1:0] ff_d,
  output logic             ff_sin,
  input  logic [WIDTH-1:0] ff_q,
  output logic             done,
  output logic             err
);
  localparam int MX = WIDTH > PULSE_LEN ? WIDTH : PULSE_LEN;
  localparam int CW = $clog2(MX + 1);
  localparam logic [2:0] IDLE = 3'd0, PULSE = 3'd1, LOAD = 3'd2, SHIFT = 3'd3, CHECK = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic pre;
  logic [WIDTH-1:0] data, expected;
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      cnt <= '0;
      pre <= 1'b0;
      data <= '0;
      expected <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          pre <= cmd_op[0];
          data <= cmd_data;
          expected <= cmd_op == 2'b00 ? '0 : cmd_op == 2'b01 ? '1 : cmd_data;
          cnt <= cmd_op[1] ? CW'(WIDTH - 1) : CW'(PULSE_LEN - 1);
          state <= cmd_op[1] ? (cmd_op[0] ? SHIFT : LOAD) : PULSE;
        end
        PULSE: if (cnt == '0) state <= CHECK; else cnt <= cnt - 1'b1;
        LOAD: state <= CHECK;
        SHIFT: begin
          // data doubles as the shift source: MSB is presented each cycle
          data <= data << 1;
          if (cnt == '0) state <= CHECK; else cnt <= cnt - 1'b1;
        end
        CHECK: begin
          err <= ff_q != expected;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign cmd_ready = clr & (state == IDLE);
  assign ff_clr_n = !(state == PULSE && !pre);
  assign ff_pre_n = !(state == PULSE && pre);
  assign ff_ce = state == LOAD || state == SHIFT;
  assign ff_mode = state == SHIFT;
  assign ff_d = state == LOAD ? data : '0;
  assign ff_sin = state == SHIFT && data[WIDTH-1];
  assign done = state == CHECK;
endmodule
